// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed, double-buffered hex display scan controller
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] Data_in,
    input  logic                    Load,
    input  logic                    Blank_en,
    output logic [3:0]              Digit_out,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic                    Frame_done
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [DW-1:0]             div_cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   disp_reg, pend_reg;
    logic                      pend_vld;
    logic                      tick, fb;
    logic [3:0]                cur_nib;
    logic [NUM_DIGITS-1:0]     cur_anode;
    logic                      cur_blank;

    assign tick = div_cnt == DIV_LAST;
    assign fb   = tick && idx == IDX_LAST;

    // select the active nibble, its anode pattern and whether it is a leading zero
    always_comb begin
        cur_nib   = '0;
        cur_anode = '1;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx == IW'(i)) begin
                cur_nib      = disp_reg[4*i +: 4];
                cur_anode[i] = 1'b0;
                cur_blank    = Blank_en && i > 0 && (disp_reg >> (4*i)) == '0;
            end
    end

    // slot divider and digit index
    always_ff @(posedge CLK or posedge Reset)
        if (Reset) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            idx     <= tick ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
        end

    // pending/display buffers; a load coinciding with the frame boundary goes straight to display
    always_ff @(posedge CLK or posedge Reset)
        if (Reset) begin
            disp_reg <= '0;
            pend_reg <= '0;
            pend_vld <= 1'b0;
        end else if (Load) begin
            pend_reg <= Data_in;
            pend_vld <= !fb;
            if (fb) disp_reg <= Data_in;
        end else if (fb && pend_vld) begin
            disp_reg <= pend_reg;
            pend_vld <= 1'b0;
        end

    // registered display outputs
    always_ff @(posedge CLK or posedge Reset)
        if (Reset) begin
            Digit_out  <= '0;
            Anode      <= '1;
            Frame_done <= 1'b0;
        end else begin
            Digit_out  <= cur_nib;
            Anode      <= cur_blank ? '1 : cur_anode;
            Frame_done <= fb;
        end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of scan order, buffering, blanking and reset
module tb_seg_scan_driver;
    logic        CLK, Reset, Load, Blank_en;
    logic [15:0] Data_in;
    logic [3:0]  Digit_out;
    logic [3:0]  Anode;
    logic        Frame_done;
    int          checks, failures;

    seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .CLK(CLK), .Reset(Reset), .Data_in(Data_in), .Load(Load), .Blank_en(Blank_en),
        .Digit_out(Digit_out), .Anode(Anode), .Frame_done(Frame_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        Data_in = v;
        Load    = 1'b1;
        @(negedge CLK);
        Load    = 1'b0;
    endtask

    task automatic wait_fd();
        for (int n = 0; n < 64; n++) begin
            @(negedge CLK);
            if (Frame_done) break;
        end
        check("fd_wait", Frame_done, 1);
    endtask

    // expects the 16 cycles following the current negedge to be one whole frame of v
    task automatic check_frame(input logic [15:0] v);
        logic [3:0] exp_an;
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < 4; c++) begin
                @(negedge CLK);
                exp_an = (Blank_en && d > 0 && (v >> (4*d)) == 16'h0) ? 4'hF : ~(4'b0001 << d);
                check("digit", Digit_out, v[4*d +: 4]);
                check("anode", Anode, exp_an);
                check("fdone", Frame_done, d == 3 && c == 3);
            end
    endtask

    initial begin
        checks = 0; failures = 0;
        Reset = 1'b1; Load = 1'b0; Blank_en = 1'b0; Data_in = 16'h0;
        for (int n = 0; n < 4; n++) begin
            Load    = n[0];
            Data_in = 16'hBEEF ^ 16'(n);
            @(negedge CLK);
            check("rst_anode", Anode, 4'hF);
            check("rst_digit", Digit_out, 0);
            check("rst_fd", Frame_done, 0);
        end
        Load  = 1'b0;
        Reset = 1'b0;
        do_load(16'h1A2F);
        wait_fd();
        check_frame(16'h1A2F);
        check_frame(16'h1A2F);
        Blank_en = 1'b1;
        do_load(16'h0030);
        wait_fd();
        check_frame(16'h0030);
        do_load(16'h0000);
        wait_fd();
        check_frame(16'h0000);
        Blank_en = 1'b0;
        do_load(16'h1111);
        repeat (5) @(negedge CLK);
        do_load(16'h2222);
        wait_fd();
        check_frame(16'h2222);
        repeat (15) @(negedge CLK);
        do_load(16'h3333);
        check("fb_load_fd", Frame_done, 1);
        check_frame(16'h3333);
        check_frame(16'h3333);
        do_load(16'h5555);
        repeat (9) @(negedge CLK);
        check("mid_d2", Anode, 4'b1011);
        Reset = 1'b1;
        #1;
        check("async_anode", Anode, 4'hF);
        check("async_digit", Digit_out, 0);
        check("async_fd", Frame_done, 0);
        @(negedge CLK);
        Reset = 1'b0;
        check_frame(16'h0000);
        check_frame(16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
